// File: rtl/sine_pkg.sv
// sine_pkg -- shared constants and types for the sine tone measurement path.
//   state_t          : measurement FSM encoding (SEEK, RUN)
//   DEF_AMP_BITS     : default sample width, shared with the tone generator
//   DEF_MID/DEF_HYST : default mid-scale crossing code and hysteresis depth
//   DEF_CNT_BITS     : default sample-count width
//   tmo_count()      : sample count at which a missing signal is declared
package sine_pkg;

   typedef enum logic {
      SEEK = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEF_AMP_BITS = 8;
   localparam int DEF_MID      = 128;
   localparam int DEF_HYST     = 8;
   localparam int DEF_CNT_BITS = 16;

   // All-ones value of a cnt_bits-wide counter; reaching it means no signal.
   function automatic int unsigned tmo_count(input int unsigned cnt_bits);
      return (32'd1 << cnt_bits) - 32'd1;
   endfunction

endpackage

// File: rtl/sine_xdet.sv
// sine_xdet -- rising mid-scale crossing detector with hysteresis.
// The detector arms once a sample falls to MID-HYST or below, and fires on the
// first later sample at or above MID. Firing disarms it, so noise around MID
// cannot produce a second event within the same period.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   sample_in     : offset-binary sample
//   sample_valid  : qualifies sample_in
//   xevent        : one-cycle crossing event, coincident with the sample
module sine_xdet
   import sine_pkg::*;
#(
   parameter int AMP_BITS = DEF_AMP_BITS,
   parameter int MID      = DEF_MID,
   parameter int HYST     = DEF_HYST
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [AMP_BITS-1:0] sample_in,
   input  logic                sample_valid,
   output logic                xevent
);

   localparam logic [AMP_BITS-1:0] MID_C = AMP_BITS'(MID);
   localparam logic [AMP_BITS-1:0] ARM_C = AMP_BITS'(MID - HYST);

   logic armed_r;
   logic xevent_s;

   // The event is combinational so the top can act on the crossing sample itself.
   assign xevent_s = sample_valid && armed_r && (sample_in >= MID_C);
   assign xevent   = xevent_s;

   // Hysteresis arm flag: set at or below the arm level, cleared by an event.
   always_ff @(posedge clk) begin
      if (rst) begin
         armed_r <= 1'b0;
      end else if (xevent_s) begin
         armed_r <= 1'b0;
      end else if (sample_valid && (sample_in <= ARM_C)) begin
         armed_r <= 1'b1;
      end
   end

endmodule

// File: rtl/sine_meas_ob.sv
// sine_meas_ob -- period / peak / lock measurement of an offset-binary sine.
// Counts valid samples between rising mid-scale crossings, sums 2^NPER_LOG2
// periods per window and reports the averaged period with window peaks.
// Optional feature: define SINE_MEAS_AMP_EN to register amplitude and
// dc_level; otherwise both ports are tied to zero.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   sample_in     : offset-binary sample, sample_valid qualifies it
//   period        : averaged period in samples (window sum >> NPER_LOG2)
//   peak_max/min  : extreme samples of the last window
//   amplitude     : (peak_max-peak_min)>>1, dc_level: (peak_max+peak_min)>>1
//   meas_valid    : one-cycle pulse when the outputs update
//   locked        : set by the first completed window, cleared by timeout
//   no_signal     : sticky timeout flag, cleared by the next crossing event
module sine_meas_ob
   import sine_pkg::*;
#(
   parameter int AMP_BITS  = DEF_AMP_BITS,
   parameter int MID       = DEF_MID,
   parameter int HYST      = DEF_HYST,
   parameter int CNT_BITS  = DEF_CNT_BITS,
   parameter int NPER_LOG2 = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [AMP_BITS-1:0] sample_in,
   input  logic                sample_valid,
   output logic [CNT_BITS-1:0] period,
   output logic [AMP_BITS-1:0] peak_max,
   output logic [AMP_BITS-1:0] peak_min,
   output logic [AMP_BITS-1:0] amplitude,
   output logic [AMP_BITS-1:0] dc_level,
   output logic                meas_valid,
   output logic                locked,
   output logic                no_signal
);

   localparam int ACC_W = CNT_BITS + NPER_LOG2;
   localparam int PC_W  = NPER_LOG2 + 1;
   localparam logic [CNT_BITS-1:0] TMO_C     = CNT_BITS'(tmo_count(CNT_BITS));
   localparam logic [CNT_BITS-1:0] CNT_ONE_C = CNT_BITS'(1);
   localparam logic [PC_W-1:0]     PC_FULL_C = PC_W'(1 << NPER_LOG2);

   state_t              state_r, state_nxt_s;
   logic                xevent_s;
   logic [CNT_BITS-1:0] cnt_r, cnt_inc_s;
   logic [ACC_W-1:0]    acc_r, acc_sum_s;
   logic [PC_W-1:0]     pcnt_r, pcnt_inc_s;
   logic [AMP_BITS-1:0] max_r, min_r, smax_s, smin_s;
   logic                tmo_s, win_done_s;
   // Window results staged for one cycle before reaching the outputs.
   logic                done_r;
   logic [ACC_W-1:0]    wsum_r;
   logic [AMP_BITS-1:0] wmax_r, wmin_r;
   logic [CNT_BITS-1:0] period_r;
   logic [AMP_BITS-1:0] peak_max_r, peak_min_r;
   logic                meas_valid_r, locked_r, no_signal_r;

   sine_xdet #(
      .AMP_BITS (AMP_BITS),
      .MID      (MID),
      .HYST     (HYST)
   ) u_xdet (
      .clk          (clk),
      .rst          (rst),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .xevent       (xevent_s)
   );

   assign cnt_inc_s  = cnt_r + CNT_ONE_C;
   assign pcnt_inc_s = pcnt_r + PC_W'(1);
   assign acc_sum_s  = acc_r + {{NPER_LOG2{1'b0}}, cnt_r};
   assign smax_s     = (sample_in > max_r) ? sample_in : max_r;
   assign smin_s     = (sample_in < min_r) ? sample_in : min_r;
   // An event restarts the count, so only non-event samples can time out.
   assign tmo_s      = sample_valid && !xevent_s && (cnt_inc_s == TMO_C);
   assign win_done_s = (state_r == RUN) && xevent_s && (pcnt_inc_s == PC_FULL_C);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= SEEK;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state: first crossing starts RUN, timeout falls back to SEEK.
   always_comb begin
      state_nxt_s = state_r;
      if (sample_valid) begin
         case (state_r)
            SEEK:    if (xevent_s) state_nxt_s = RUN;  else state_nxt_s = SEEK;
            RUN:     if (tmo_s)    state_nxt_s = SEEK; else state_nxt_s = RUN;
            default: state_nxt_s = SEEK;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Period counter, window accumulator, running peaks and window staging.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r       <= '0;
         acc_r       <= '0;
         pcnt_r      <= '0;
         max_r       <= '0;
         min_r       <= '0;
         done_r      <= 1'b0;
         wsum_r      <= '0;
         wmax_r      <= '0;
         wmin_r      <= '0;
         no_signal_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (sample_valid) begin
            if (xevent_s) begin
               no_signal_r <= 1'b0;
            end
            if (tmo_s) begin
               no_signal_r <= 1'b1;
               cnt_r       <= '0;
               acc_r       <= '0;
               pcnt_r      <= '0;
            end else begin
               case (state_r)
                  SEEK: begin
                     if (xevent_s) begin
                        cnt_r  <= CNT_ONE_C;
                        acc_r  <= '0;
                        pcnt_r <= '0;
                        max_r  <= sample_in;
                        min_r  <= sample_in;
                     end else begin
                        cnt_r <= cnt_inc_s;
                     end
                  end
                  RUN: begin
                     if (win_done_s) begin
                        // Close the window and re-seed the next one back-to-back.
                        wsum_r <= acc_sum_s;
                        wmax_r <= smax_s;
                        wmin_r <= smin_s;
                        done_r <= 1'b1;
                        cnt_r  <= CNT_ONE_C;
                        acc_r  <= '0;
                        pcnt_r <= '0;
                        max_r  <= sample_in;
                        min_r  <= sample_in;
                     end else if (xevent_s) begin
                        cnt_r  <= CNT_ONE_C;
                        acc_r  <= acc_sum_s;
                        pcnt_r <= pcnt_inc_s;
                        max_r  <= smax_s;
                        min_r  <= smin_s;
                     end else begin
                        cnt_r <= cnt_inc_s;
                        max_r <= smax_s;
                        min_r <= smin_s;
                     end
                  end
                  default: begin
                     cnt_r <= '0;
                  end
               endcase
            end
         end
      end
   end

   // Output registers: publish a staged window, drop lock on timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         period_r     <= '0;
         peak_max_r   <= '0;
         peak_min_r   <= '0;
         meas_valid_r <= 1'b0;
         locked_r     <= 1'b0;
      end else begin
         meas_valid_r <= done_r;
         if (done_r) begin
            period_r   <= CNT_BITS'(wsum_r >> NPER_LOG2);
            peak_max_r <= wmax_r;
            peak_min_r <= wmin_r;
            locked_r   <= 1'b1;
         end else if (tmo_s) begin
            locked_r   <= 1'b0;
         end
      end
   end

   assign period     = period_r;
   assign peak_max   = peak_max_r;
   assign peak_min   = peak_min_r;
   assign meas_valid = meas_valid_r;
   assign locked     = locked_r;
   assign no_signal  = no_signal_r;

`ifdef SINE_MEAS_AMP_EN
   // One extra bit keeps the sum from wrapping before the halving.
   logic [AMP_BITS:0]   amp_diff_s, dc_sum_s;
   logic [AMP_BITS-1:0] amplitude_r, dc_level_r;

   assign amp_diff_s = {1'b0, wmax_r} - {1'b0, wmin_r};
   assign dc_sum_s   = {1'b0, wmax_r} + {1'b0, wmin_r};

   // Amplitude and DC level update together with the other window outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         amplitude_r <= '0;
         dc_level_r  <= '0;
      end else if (done_r) begin
         amplitude_r <= amp_diff_s[AMP_BITS:1];
         dc_level_r  <= dc_sum_s[AMP_BITS:1];
      end
   end

   assign amplitude = amplitude_r;
   assign dc_level  = dc_level_r;
`else
   assign amplitude = {AMP_BITS{1'b0}};
   assign dc_level  = {AMP_BITS{1'b0}};
`endif

endmodule
